// File: rtl/onehot_seq_decoder_pkg.sv
// Shared types for the one-hot sequencing decoder: sequencer states and mode encodings.
package onehot_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SCAN  = 2'd2
  } state_e;

  localparam logic [MODE_W-1:0] MODE_DIRECT = 2'b00;
  localparam logic [MODE_W-1:0] MODE_PULSE  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SCAN   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_OFF    = 2'b11;

endpackage

// File: rtl/onehot_seq_decoder_if.sv
// Control/status bundle between a sequencing master and the one-hot decoder.
interface onehot_seq_decoder_if
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W = 5,
  parameter int LEN_W = 8
);
  logic                    en;
  logic [MODE_W-1:0]       mode;
  logic [SEL_W-1:0]        select;
  logic                    start;
  logic                    stop;
  logic [LEN_W-1:0]        len;
  logic [(1<<SEL_W)-1:0]   out;
  logic [SEL_W-1:0]        pos;
  logic                    busy;
  logic                    done;

  modport master (
    output en, mode, select, start, stop, len,
    input  out, pos, busy, done
  );

  modport slave (
    input  en, mode, select, start, stop, len,
    output out, pos, busy, done
  );
endinterface

// File: rtl/onehot_seq_decoder_dec.sv
// Combinational select -> one-hot decode, gated to all-zero when en is low.
module onehot_dec #(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] onehot
);
  localparam int N_OUT = 1 << SEL_W;

  for (genvar i = 0; i < N_OUT; i++) begin : g_line
    assign onehot[i] = en && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered one-hot decoder with DIRECT, PULSE and SCAN sequencing; every output is a flop.
module onehot_seq_decoder
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W = 5,
  parameter int LEN_W = 8,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_seq_decoder_if.slave  bus
);
  localparam int N_OUT = 1 << SEL_W;
  localparam int DW_W  = $clog2(DWELL + 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   pos_q, pos_d;
  logic [N_OUT-1:0]   out_q, out_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drive_d;

  // cnt_q: remaining active cycles (PULSE) or positions (SCAN), including the one on display.
  // A SCAN launched with len=0 keeps cnt_q at 0 and never reaches the end condition.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drive_d = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (bus.mode == MODE_DIRECT) begin
            pos_d   = bus.select;
            drive_d = 1'b1;
          end else if (bus.start && !bus.stop) begin
            if (bus.mode == MODE_PULSE) begin
              if (bus.len == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = PULSE;
                pos_d   = bus.select;
                cnt_d   = bus.len;
                busy_d  = 1'b1;
                drive_d = 1'b1;
              end
            end else if (bus.mode == MODE_SCAN) begin
              state_d = SCAN;
              pos_d   = bus.select;
              cnt_d   = bus.len;
              dwell_d = DW_W'(1);
              busy_d  = 1'b1;
              drive_d = 1'b1;
            end
          end
        end

        PULSE: begin
          if (bus.stop || cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            drive_d = 1'b1;
          end
        end

        SCAN: begin
          if (bus.stop || (dwell_q == DW_W'(DWELL) && cnt_q == LEN_W'(1))) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (dwell_q == DW_W'(DWELL)) begin
            pos_d   = pos_q + SEL_W'(1);
            dwell_d = DW_W'(1);
            if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
            drive_d = 1'b1;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
            drive_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel    (pos_d),
    .en     (drive_d),
    .onehot (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.pos  = pos_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Randomized and directed check of onehot_seq_decoder against a sequence-level reference model.
module tb_onehot_seq_decoder;
  localparam int SEL_W = 5;
  localparam int LEN_W = 8;
  localparam int DWELL = 4;
  localparam int N_OUT = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_seq_decoder_if #(.SEL_W(SEL_W), .LEN_W(LEN_W)) bus ();

  onehot_seq_decoder #(.SEL_W(SEL_W), .LEN_W(LEN_W), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    errs   = 0;
  int    checks = 0;
  string phase  = "init";

  // Reference model: a sequence is a base line, a length and a count of displayed cycles.
  bit               m_act, m_scan, m_busy, m_done;
  int               m_base, m_len, m_t;
  logic [N_OUT-1:0] m_out;
  logic [SEL_W-1:0] m_pos;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic show();
    int p;
    p = m_scan ? (m_base + (m_t - 1) / DWELL) % N_OUT : m_base;
    m_pos  = SEL_W'(p);
    m_out  = N_OUT'(1) << p;
    m_busy = 1'b1;
  endtask

  task automatic model_step();
    int lim;
    if (rst) begin
      m_act = 0; m_out = '0; m_pos = '0; m_busy = 0; m_done = 0;
      return;
    end
    if (!bus.en) begin
      m_out = '0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!m_act) begin
      m_busy = 0;
      m_out  = '0;
      if (bus.mode == 2'b00) begin
        m_pos = bus.select;
        m_out = N_OUT'(1) << bus.select;
      end else if (bus.start && !bus.stop) begin
        if (bus.mode == 2'b01 && bus.len == 0) begin
          m_done = 1;
        end else if (bus.mode != 2'b11) begin
          m_act  = 1;
          m_scan = (bus.mode == 2'b10);
          m_base = int'(bus.select);
          m_len  = int'(bus.len);
          m_t    = 1;
          show();
        end
      end
    end else begin
      lim = m_scan ? m_len * DWELL : m_len;
      if (bus.stop || (lim != 0 && m_t == lim)) begin
        m_act = 0; m_out = '0; m_busy = 0; m_done = 1;
      end else begin
        m_t++;
        show();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("out",  bus.out,  m_out);
    chk("pos",  bus.pos,  m_pos);
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_done);
  endtask

  task automatic drive(input bit e, input bit [1:0] md, input int sel,
                       input bit st, input bit sp, input int ln);
    bus.en     = e;
    bus.mode   = md;
    bus.select = SEL_W'(sel);
    bus.start  = st;
    bus.stop   = sp;
    bus.len    = LEN_W'(ln);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    drive(1, 2'b11, 0, 0, 0, 0);
    cycle();
    cycle();
    phase = "reset";
    chk("out0", bus.out, 0);
    chk("pos0", bus.pos, 0);
    chk("busy0", bus.busy, 0);
    chk("done0", bus.done, 0);
    rst = 1'b0;

    phase = "direct";
    drive(1, 2'b00, 0, 0, 0, 0);  cycle(); chk("sel0", bus.out, 32'h1);
    drive(1, 2'b00, 7, 0, 0, 0);  cycle(); chk("sel7", bus.out, 32'h80);
    drive(1, 2'b00, 31, 0, 0, 0); cycle(); chk("sel31", bus.out, 32'h8000_0000);
    chk("busy", bus.busy, 0);

    phase = "pulse";
    drive(1, 2'b11, 0, 0, 0, 0); cycle();
    drive(1, 2'b01, 9, 1, 0, 3); cycle();
    chk("c1out", bus.out, 32'h200);
    chk("c1busy", bus.busy, 1);
    bus.start = 1'b0;
    cycle(); cycle();
    chk("c3out", bus.out, 32'h200);
    cycle();
    chk("c4out", bus.out, 0);
    chk("c4done", bus.done, 1);
    chk("c4busy", bus.busy, 0);
    drive(1, 2'b01, 9, 1, 0, 0); cycle();
    chk("len0done", bus.done, 1);
    chk("len0out", bus.out, 0);
    bus.start = 1'b0; cycle();

    phase = "scan";
    drive(1, 2'b10, 30, 1, 0, 4);
    for (int k = 0; k < 16; k++) begin
      cycle();
      bus.start = 1'b0;
      chk("pos", bus.pos, (30 + k / DWELL) % N_OUT);
    end
    cycle();
    chk("end_done", bus.done, 1);
    chk("end_out", bus.out, 0);

    phase = "scan_stop";
    drive(1, 2'b10, 5, 1, 0, 0); cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) cycle();
    bus.stop = 1'b1; cycle();
    chk("out", bus.out, 0);
    chk("done", bus.done, 1);
    drive(1, 2'b01, 3, 1, 1, 5); cycle();
    chk("startstop_busy", bus.busy, 0);
    drive(1, 2'b01, 3, 0, 0, 5); cycle();
    chk("startstop_busy2", bus.busy, 0);

    phase = "pulse_en";
    drive(1, 2'b01, 12, 1, 0, 6); cycle();
    bus.start = 1'b0;
    cycle(); cycle();
    bus.en = 1'b0;
    cycle(); chk("frz1", bus.out, 0);
    cycle(); chk("frz2", bus.out, 0);
    bus.en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.start = (i < 2);
      cycle();
      if (bus.out != 0) cnt++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk("resume_cycles", cnt, 3);
    chk("resume_done", bus.done, 1);

    phase = "rst_mid";
    drive(1, 2'b10, 20, 1, 0, 0); cycle();
    bus.start = 1'b0; cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("scan_out", bus.out, 0);
    chk("scan_pos", bus.pos, 0);
    chk("scan_busy", bus.busy, 0);
    drive(1, 2'b01, 4, 1, 0, 9); cycle();
    bus.start = 1'b0; cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("pulse_out", bus.out, 0);
    chk("pulse_busy", bus.busy, 0);
    chk("pulse_done", bus.done, 0);
    drive(1, 2'b00, 17, 0, 0, 0); cycle();
    chk("direct_after", bus.out, 32'h2_0000);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), int'($urandom_range(0, N_OUT - 1)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
